// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and hex-to-segment table for the display scan block
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;

    localparam logic [NUM_DIGITS-1:0] EN_ALL_OFF = 4'hF;

    // Segment masks ordered {A,B,C,D,E,F,G}; bit 6 is segment A, 1 = lit.
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h7E,  // 0
        7'h30,  // 1
        7'h6D,  // 2
        7'h79,  // 3
        7'h33,  // 4
        7'h5B,  // 5
        7'h5F,  // 6
        7'h70,  // 7
        7'h7F,  // 8
        7'h7B,  // 9
        7'h77,  // A
        7'h1F,  // b
        7'h4E,  // C
        7'h3D,  // d
        7'h4F,  // E
        7'h47   // F
    };

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational hex nibble to 7-segment mask lookup
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0]       i_nibble,
    output logic [SEG_W-1:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit 7-segment scan scheduler with blanking, PWM and frame-synchronous load
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int CLK_DIV      = 4096,
    parameter int BLANK_CYCLES = 64,
    parameter int BRIGHT_W     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load_valid,
    input  logic [15:0]           i_load_data,
    output logic                  o_load_ready,
    input  logic [BRIGHT_W-1:0]   i_bright,
    output logic [NUM_DIGITS-1:0] o_en_n,
    output logic [SEG_W-1:0]      o_seg,
    output logic [1:0]            o_cur_digit,
    output logic                  o_frame_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]      r_slot_cnt;
    logic [1:0]            r_cur_digit;
    logic [15:0]           r_disp;
    logic [15:0]           r_pend;
    logic                  r_pend_full;
    logic [BRIGHT_W-1:0]   r_bright;
    logic [NUM_DIGITS-1:0] r_en_n;
    logic [SEG_W-1:0]      r_seg;
    logic                  r_frame_done;

    logic                  w_slot_end;
    logic                  w_boundary;
    logic                  w_transfer;
    logic                  w_blank;
    logic                  w_pwm_on;
    logic [BRIGHT_W-1:0]   w_phase;
    logic [3:0]            w_nibble;
    logic [SEG_W-1:0]      w_seg_dec;
    logic [NUM_DIGITS-1:0] w_en_on;

    assign w_slot_end = (r_slot_cnt == SLOT_LAST);
    assign w_boundary = w_slot_end && (r_cur_digit == 2'd3);
    assign w_transfer = i_load_valid && !r_pend_full;

    // The blank window vanishes entirely when BLANK_CYCLES is zero.
    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            localparam logic [CNT_W-1:0] BLANK_L = CNT_W'(BLANK_CYCLES);
            assign w_blank = (r_slot_cnt < BLANK_L);
        end else begin : g_no_blank
            assign w_blank = 1'b0;
        end
    endgenerate

    // PWM phase is the low bits of the slot counter, so duty repeats every 2^BRIGHT_W cycles.
    assign w_phase  = r_slot_cnt[BRIGHT_W-1:0];
    assign w_pwm_on = (&r_bright) || (w_phase < r_bright);

    assign w_nibble = r_disp[{r_cur_digit, 2'b00} +: 4];
    assign w_en_on  = ~(4'b0001 << r_cur_digit);

    seg7_decoder u_seg7_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    // Slot counter and digit index form the frame timebase.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot_cnt  <= '0;
            r_cur_digit <= 2'd0;
        end else if (w_slot_end) begin
            r_slot_cnt  <= '0;
            r_cur_digit <= r_cur_digit + 2'd1;
        end else begin
            r_slot_cnt  <= r_slot_cnt + 1'b1;
        end
    end

    // Pending buffer fills on handshake and drains into the display only at the frame boundary.
    // A full buffer blocks the handshake, so capture and commit never coincide.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_disp      <= 16'h0000;
            r_pend      <= 16'h0000;
            r_pend_full <= 1'b0;
        end else if (w_boundary && r_pend_full) begin
            r_disp      <= r_pend;
            r_pend_full <= 1'b0;
        end else if (w_transfer) begin
            r_pend      <= i_load_data;
            r_pend_full <= 1'b1;
        end
    end

    // Brightness is resampled once per frame so a frame never mixes two duty levels.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bright <= '1;
        end else if (w_boundary) begin
            r_bright <= i_bright;
        end
    end

    // Registered pin drive: one cycle behind the timebase, dark during blank or PWM-off.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_en_n       <= EN_ALL_OFF;
            r_seg        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (w_blank || !w_pwm_on) begin
                r_en_n <= EN_ALL_OFF;
                r_seg  <= '0;
            end else begin
                r_en_n <= w_en_on;
                r_seg  <= w_seg_dec;
            end
        end
    end

    assign o_load_ready = !r_pend_full;
    assign o_en_n       = r_en_n;
    assign o_seg        = r_seg;
    assign o_cur_digit  = r_cur_digit;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [15:0] load_data;
    logic [3:0]  bright;
    logic        load_ready;
    logic [3:0]  en_n;
    logic [6:0]  seg;
    logic [1:0]  cur_digit;
    logic        frame_done;

    logic        load_valid2;
    logic [15:0] load_data2;
    logic [3:0]  bright2;
    logic        load_ready2;
    logic [3:0]  en_n2;
    logic [6:0]  seg2;
    logic [1:0]  cur_digit2;
    logic        frame_done2;

    int n_cmp  = 0;
    int n_fail = 0;
    int k      = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.CLK_DIV(32), .BLANK_CYCLES(4), .BRIGHT_W(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load_valid (load_valid),
        .i_load_data  (load_data),
        .o_load_ready (load_ready),
        .i_bright     (bright),
        .o_en_n       (en_n),
        .o_seg        (seg),
        .o_cur_digit  (cur_digit),
        .o_frame_done (frame_done)
    );

    display_scan_ctrl #(.CLK_DIV(20), .BLANK_CYCLES(0), .BRIGHT_W(4)) dut2 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load_valid (load_valid2),
        .i_load_data  (load_data2),
        .o_load_ready (load_ready2),
        .i_bright     (bright2),
        .o_en_n       (en_n2),
        .o_seg        (seg2),
        .o_cur_digit  (cur_digit2),
        .o_frame_done (frame_done2)
    );

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    // Expected enables for timebase state s (position within a frame).
    function automatic logic [3:0] exp_en(input int s, input int div, input int blank, input int br);
        int p;
        int d;
        p = s % div;
        d = (s / div) % 4;
        if (p < blank) return 4'hF;
        if (br == 15 || (p % 16) < br) return ~(4'b0001 << d);
        return 4'hF;
    endfunction

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic step_to(input int target);
        while (k < target) step();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        bright = 4'hF;
        step_to(20);
        load_valid = 1'b1;
        load_data  = 16'hBEEF;
        step();
        load_valid = 1'b0;
        step_to(40);
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pre_pend_full ready=%b exp=0", load_ready); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (en_n !== 4'hF) begin n_fail++; $display("FAIL reset_en_n got=%h exp=F", en_n); end
        n_cmp++; if (seg !== 7'h00) begin n_fail++; $display("FAIL reset_seg got=%h exp=00", seg); end
        n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        n_cmp++; if (cur_digit !== 2'd0) begin n_fail++; $display("FAIL reset_cur_digit got=%0d exp=0", cur_digit); end
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        step_to(4);
        n_cmp++; if (en_n !== 4'hF) begin n_fail++; $display("FAIL post_reset_blank en_n=%h exp=F", en_n); end
        step_to(5);
        n_cmp++; if (en_n !== 4'b1110) begin n_fail++; $display("FAIL post_reset_digit0_en en_n=%b exp=1110", en_n); end
        n_cmp++; if (seg !== 7'h7E) begin n_fail++; $display("FAIL post_reset_digit0_seg seg=%h exp=7e", seg); end
    endtask

    task automatic test_scan();
        logic [3:0] e;
        do_reset();
        bright = 4'hF;
        for (int i = 0; i < 256; i++) begin
            step();
            e = exp_en((k - 1) % 128, 32, 4, 15);
            n_cmp++; if (en_n !== e) begin n_fail++; $display("FAIL scan_en k=%0d got=%b exp=%b", k, en_n, e); end
            n_cmp++; if (seg !== ((e == 4'hF) ? 7'h00 : 7'h7E)) begin n_fail++; $display("FAIL scan_seg k=%0d got=%h", k, seg); end
            n_cmp++; if (frame_done !== (k % 128 == 0)) begin n_fail++; $display("FAIL scan_frame_done k=%0d got=%b", k, frame_done); end
            n_cmp++; if (cur_digit !== 2'((k % 128) / 32)) begin n_fail++; $display("FAIL scan_cur_digit k=%0d got=%0d exp=%0d", k, cur_digit, (k % 128) / 32); end
        end
    endtask

    task automatic test_load();
        logic [3:0] digs [4];
        digs = '{4'h4, 4'h3, 4'h2, 4'h1};
        do_reset();
        bright = 4'hF;
        step_to(10);
        load_valid = 1'b1;
        load_data  = 16'h1234;
        step();
        load_valid = 1'b0;
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_low k=11 got=%b exp=0", load_ready); end
        step_to(127);
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_hold k=127 got=%b exp=0", load_ready); end
        n_cmp++; if (seg !== 7'h7E) begin n_fail++; $display("FAIL load_no_tear k=127 seg=%h exp=7e", seg); end
        step_to(128);
        n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_back k=128 got=%b exp=1", load_ready); end
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL load_frame_done k=128 got=%b exp=1", frame_done); end
        n_cmp++; if (seg !== 7'h7E) begin n_fail++; $display("FAIL load_lag k=128 seg=%h exp=7e", seg); end
        for (int d = 0; d < 4; d++) begin
            step_to(128 + 32 * d + 5);
            n_cmp++; if (seg !== hex7(digs[d])) begin n_fail++; $display("FAIL load_digit%0d seg=%h exp=%h", d, seg, hex7(digs[d])); end
            n_cmp++; if (en_n !== ~(4'b0001 << d)) begin n_fail++; $display("FAIL load_digit%0d_en en_n=%b", d, en_n); end
        end
    endtask

    task automatic test_bright();
        int on_cnt;
        do_reset();
        bright = 4'h0;
        on_cnt = 0;
        for (int i = 0; i < 32; i++) begin step(); if (en_n !== 4'hF) on_cnt++; end
        n_cmp++; if (on_cnt !== 28) begin n_fail++; $display("FAIL bright_reset_full on=%0d exp=28", on_cnt); end
        step_to(128);
        on_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            if (en_n !== 4'hF) on_cnt++;
            if (k == 200) bright = 4'h8;
        end
        n_cmp++; if (on_cnt !== 0) begin n_fail++; $display("FAIL bright_zero_dark on=%0d exp=0", on_cnt); end
        for (int s = 0; s < 4; s++) begin
            on_cnt = 0;
            for (int i = 0; i < 32; i++) begin
                step();
                if (en_n !== 4'hF) on_cnt++;
                if (k == 300) bright = 4'hF;
            end
            n_cmp++; if (on_cnt !== 12) begin n_fail++; $display("FAIL bright_half slot=%0d on=%0d exp=12", s, on_cnt); end
        end
        on_cnt = 0;
        for (int i = 0; i < 32; i++) begin step(); if (en_n !== 4'hF) on_cnt++; end
        n_cmp++; if (on_cnt !== 28) begin n_fail++; $display("FAIL bright_next_frame on=%0d exp=28", on_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bright = 4'hF;
        step_to(2);
        load_valid = 1'b1;
        load_data  = 16'h5678;
        step();
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_a_taken ready=%b exp=0", load_ready); end
        load_data = 16'h9ABC;
        step_to(128);
        n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_a_commit ready=%b exp=1", load_ready); end
        step();
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_b_taken ready=%b exp=0", load_ready); end
        load_valid = 1'b0;
        step_to(133);
        n_cmp++; if (seg !== hex7(4'h8)) begin n_fail++; $display("FAIL b2b_a_shown seg=%h exp=%h", seg, hex7(4'h8)); end
        step_to(261);
        n_cmp++; if (seg !== hex7(4'hC)) begin n_fail++; $display("FAIL b2b_b_shown seg=%h exp=%h", seg, hex7(4'hC)); end
        step_to(383);
        n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_before_edge ready=%b exp=1", load_ready); end
        load_valid = 1'b1;
        load_data  = 16'h00EF;
        step();
        load_valid = 1'b0;
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_edge_capture ready=%b exp=0", load_ready); end
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_edge_frame_done got=%b exp=1", frame_done); end
        step_to(389);
        n_cmp++; if (seg !== hex7(4'hC)) begin n_fail++; $display("FAIL b2b_edge_not_committed seg=%h exp=%h", seg, hex7(4'hC)); end
        step_to(512);
        n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_edge_commit ready=%b exp=1", load_ready); end
        step_to(517);
        n_cmp++; if (seg !== hex7(4'hF)) begin n_fail++; $display("FAIL b2b_c_digit0 seg=%h exp=%h", seg, hex7(4'hF)); end
        step_to(549);
        n_cmp++; if (seg !== hex7(4'hE)) begin n_fail++; $display("FAIL b2b_c_digit1 seg=%h exp=%h", seg, hex7(4'hE)); end
        n_cmp++; if (en_n !== 4'b1101) begin n_fail++; $display("FAIL b2b_c_digit1_en en_n=%b exp=1101", en_n); end
    endtask

    task automatic test_small_div();
        logic [3:0] e;
        do_reset();
        for (int i = 0; i < 160; i++) begin
            step();
            e = exp_en((k - 1) % 80, 20, 0, 15);
            n_cmp++; if (en_n2 !== e) begin n_fail++; $display("FAIL div20_en k=%0d got=%b exp=%b", k, en_n2, e); end
            n_cmp++; if (seg2 !== 7'h7E) begin n_fail++; $display("FAIL div20_seg k=%0d got=%h exp=7e", k, seg2); end
            n_cmp++; if (cur_digit2 !== 2'((k % 80) / 20)) begin n_fail++; $display("FAIL div20_cur_digit k=%0d got=%0d exp=%0d", k, cur_digit2, (k % 80) / 20); end
            n_cmp++; if (frame_done2 !== (k % 80 == 0)) begin n_fail++; $display("FAIL div20_frame_done k=%0d got=%b", k, frame_done2); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        load_valid  = 1'b0;
        load_data   = 16'h0000;
        bright      = 4'hF;
        load_valid2 = 1'b0;
        load_data2  = 16'h0000;
        bright2     = 4'hF;
        test_reset();
        test_scan();
        test_load();
        test_bright();
        test_back_to_back();
        test_small_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
